// File: rtl/input32_port.sv
// -----------------------------------------------------------------------------
// input32_port
//
// Memory-mapped 32-bit switch input port with a debounced capture key.
// A capture pulse latches the synchronized switch word into a data register.
// It also sets the ready flag, which drives irq, and bumps a 16-bit capture
// count. The CPU reads the data, status, live switches or count. Reading the
// data register acknowledges ready.
//
// Ports:
//   clk       - single clock, all state changes on its rising edge
//   rst       - asynchronous, active-low reset
//   ReDEVI    - CPU read strobe (Dout loads the selected word next edge)
//   WeDEVI    - CPU write strobe
//   DEV_Addr  - register select: 00 data, 01 status, 10 live sw, 11 count
//   Din       - CPU write data
//   sw        - asynchronous switch word
//   key       - asynchronous capture key, active-high
//   Dout      - registered CPU read data
//   irq       - level interrupt request, equal to the ready flag
//
// Build option:
//   INPUT32_DEBOUNCE_EN - when defined, the key passes through a debounce FSM.
//                         It needs DEBOUNCE_CYCLES stable clocks to accept a
//                         level change. When undefined, every rising edge of
//                         the synchronized key captures. In that build,
//                         DEBOUNCE_CYCLES is only range-checked.
// -----------------------------------------------------------------------------
module input32_port #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReDEVI,
    input  logic        WeDEVI,
    input  logic [1:0]  DEV_Addr,
    input  logic [31:0] Din,
    input  logic [31:0] sw,
    input  logic        key,
    output logic [31:0] Dout,
    output logic        irq
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
        $error("input32_port: DEBOUNCE_CYCLES must be in 2..65535");
    end

    // ---------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous inputs
    // ---------------------------------------------------------------------
    logic [31:0] sw_meta_q, sw_meta_d, sw_s_q, sw_s_d;
    logic        key_meta_q, key_meta_d, key_s_q, key_s_d;

    always_comb begin
        sw_meta_d  = sw;
        sw_s_d     = sw_meta_q;
        key_meta_d = key;
        key_s_d    = key_meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_s_q     <= sw_s_d;
            key_meta_q <= key_meta_d;
            key_s_q    <= key_s_d;
        end
    end

    // ---------------------------------------------------------------------
    // Capture source: debounce FSM or plain rising-edge detect
    // ---------------------------------------------------------------------
    logic capture;
    logic key_debounced;

`ifdef INPUT32_DEBOUNCE_EN
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam logic [15:0] STABLE_LAST = 16'(DEBOUNCE_CYCLES - 1);

    key_state_t  state_q, state_d;
    logic [15:0] stable_cnt_q, stable_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RELEASED;
            stable_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        capture      = 1'b0;
        case (state_q)
            RELEASED: begin
                if (key_s_q) begin
                    state_d      = PRESS_WAIT;
                    stable_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s_q) begin
                    state_d = RELEASED;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    state_d = PRESSED;
                    capture = 1'b1;
                end else begin
                    stable_cnt_d = stable_cnt_q + 16'd1;
                end
            end
            PRESSED: begin
                if (!key_s_q) begin
                    state_d      = RELEASE_WAIT;
                    stable_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to 1 means the key never really let go, so
                // the key returns to PRESSED without a second capture.
                if (key_s_q) begin
                    state_d = PRESSED;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    state_d = RELEASED;
                end else begin
                    stable_cnt_d = stable_cnt_q + 16'd1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    assign key_debounced = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
`else
    logic key_prev_q, key_prev_d;

    always_comb key_prev_d = key_s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_prev_q <= 1'b0;
        else      key_prev_q <= key_prev_d;
    end

    assign capture       = key_s_q & ~key_prev_q;
    assign key_debounced = key_s_q;
`endif

    // ---------------------------------------------------------------------
    // CPU-visible registers
    // ---------------------------------------------------------------------
    logic [31:0] data_q, data_d;
    logic [15:0] count_q, count_d;
    logic        ready_q, ready_d;
    logic        overrun_q, overrun_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] rd_word;
    logic        rd_data, wr_status, wr_count;
    logic        unused_din_bits;

    assign unused_din_bits = ^Din[31:16];

    assign rd_data   = ReDEVI && (DEV_Addr == 2'b00);
    assign wr_status = WeDEVI && (DEV_Addr == 2'b01);
    assign wr_count  = WeDEVI && (DEV_Addr == 2'b11);

    always_comb begin
        rd_word = data_q;
        case (DEV_Addr)
            2'b00: rd_word = data_q;
            2'b01: rd_word = {29'b0, key_debounced, overrun_q, ready_q};
            2'b10: rd_word = sw_s_q;
            2'b11: rd_word = {16'b0, count_q};
            default: rd_word = data_q;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        count_d   = count_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        dout_d    = dout_q;

        // Dout samples the old contents, so a capture and a data read in the
        // same cycle return the previous word.
        if (ReDEVI) dout_d = rd_word;

        if (capture) data_d = sw_s_q;

        // A capture wins over a simultaneous read acknowledge. The new word
        // has not been read yet.
        if (capture)      ready_d = 1'b1;
        else if (rd_data) ready_d = 1'b0;

        // An unread word being replaced sets overrun. The read acknowledge
        // in the same cycle counts as having consumed the old word.
        if (capture && ready_q && !rd_data) overrun_d = 1'b1;
        else if (wr_status && Din[1])       overrun_d = 1'b0;

        if (wr_count)     count_d = Din[15:0] + {15'b0, capture};
        else if (capture) count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            data_q    <= data_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            dout_q    <= dout_d;
        end
    end

    assign Dout = dout_q;
    assign irq  = ready_q;

endmodule

// File: tb/tb_input32_port.sv
module tb_input32_port;

    localparam int DB = 4;
`ifdef INPUT32_DEBOUNCE_EN
    localparam int CAP_LAT = 3 + DB;   // sync (2) + RELEASED->PRESS_WAIT (1) + DB
`else
    localparam int CAP_LAT = 3;        // sync (2) + edge detect (1)
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ReDEVI = 1'b0;
    logic        WeDEVI = 1'b0;
    logic [1:0]  DEV_Addr = 2'b00;
    logic [31:0] Din = '0;
    logic [31:0] sw = '0;
    logic        key = 1'b0;
    logic [31:0] Dout;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    input32_port #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .ReDEVI(ReDEVI), .WeDEVI(WeDEVI),
        .DEV_Addr(DEV_Addr), .Din(Din), .sw(sw), .key(key),
        .Dout(Dout), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        ReDEVI = 1'b1; DEV_Addr = a;
        tick(1);
        ReDEVI = 1'b0;
        v = Dout;
        $display("rd  addr=%0d data=%h irq=%0b", a, v, irq);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        WeDEVI = 1'b1; DEV_Addr = a; Din = d;
        tick(1);
        WeDEVI = 1'b0;
        $display("wr  addr=%0d data=%h", a, d);
    endtask

    task automatic press();
        key = 1'b1; tick(12);
        key = 1'b0; tick(12);
        $display("press sw=%h", sw);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        tick(2);
        n_cmp++; if (Dout !== 32'h0) begin n_err++; $display("FAIL rst_dout: got %h expected %h", Dout, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b expected 0", irq); end
        sw = 32'hA5A50F0F;
        rst = 1'b1;
        tick(3);
        rd(2'b00, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h expected %h", v, 32'h0); end
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_status: got %h expected %h", v, 32'h0); end
        rd(2'b11, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_count: got %h expected %h", v, 32'h0); end
        rd(2'b10, v);
        n_cmp++; if (v !== 32'hA5A50F0F) begin n_err++; $display("FAIL rst_sw: got %h expected %h", v, 32'hA5A50F0F); end
    endtask

    task automatic test_capture();
        logic [31:0] v;
        sw = 32'hDEADBEEF;
        key = 1'b1;
        tick(10);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL cap_irq: got %b expected 1", irq); end
        rd(2'b00, v);
        n_cmp++; if (v !== 32'hDEADBEEF) begin n_err++; $display("FAIL cap_data: got %h expected %h", v, 32'hDEADBEEF); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL cap_irq_clr: got %b expected 0", irq); end
        rd(2'b11, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL cap_count: got %h expected %h", v, 32'h1); end
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h4) begin n_err++; $display("FAIL cap_status_held: got %h expected %h", v, 32'h4); end
        key = 1'b0;
        tick(10);
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL cap_status_rel: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_write_ignored();
        logic [31:0] v;
        wr(2'b00, 32'h11111111);
        wr(2'b10, 32'h22222222);
        rd(2'b00, v);
        n_cmp++; if (v !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr00_ignored: got %h expected %h", v, 32'hDEADBEEF); end
        rd(2'b10, v);
        n_cmp++; if (v !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr10_ignored: got %h expected %h", v, 32'hDEADBEEF); end
    endtask

    task automatic test_bounce();
        logic [31:0] v;
        logic [31:0] exp_cnt;
        logic [31:0] exp_st;
`ifdef INPUT32_DEBOUNCE_EN
        exp_cnt = 32'h0; exp_st = 32'h0;
`else
        exp_cnt = 32'h5; exp_st = 32'h3;
`endif
        wr(2'b11, 32'h0);
        repeat (5) begin
            key = 1'b1; tick(2);
            key = 1'b0; tick(2);
        end
        tick(10);
        rd(2'b11, v);
        n_cmp++; if (v !== exp_cnt) begin n_err++; $display("FAIL bounce_count: got %h expected %h", v, exp_cnt); end
        rd(2'b01, v);
        n_cmp++; if (v !== exp_st) begin n_err++; $display("FAIL bounce_status: got %h expected %h", v, exp_st); end
        rd(2'b00, v);
        wr(2'b01, 32'h2);
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL bounce_cleanup: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        wr(2'b11, 32'h0);
        sw = 32'h00000001; press();
        sw = 32'h00000002; press();
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL ovr_status: got %h expected %h", v, 32'h3); end
        rd(2'b11, v);
        n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL ovr_count: got %h expected %h", v, 32'h2); end
        wr(2'b01, 32'h2);
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL ovr_clear: got %h expected %h", v, 32'h1); end
        rd(2'b00, v);
        n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL ovr_data: got %h expected %h", v, 32'h2); end
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL ovr_ack: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        wr(2'b11, 32'h0000FFFF);
        sw = 32'hCAFE0000; press();
        rd(2'b11, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL wrap_count: got %h expected %h", v, 32'h0); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL wrap_irq: got %b expected 1", irq); end
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL wrap_status: got %h expected %h", v, 32'h1); end
    endtask

    // Capture edges collide with CPU accesses; ready is 1 on entry.
    task automatic test_same_cycle();
        logic [31:0] v;
        sw = 32'h0BADF00D;
        tick(3);
        key = 1'b1; tick(CAP_LAT - 1);
        ReDEVI = 1'b1; DEV_Addr = 2'b00;
        tick(1);
        ReDEVI = 1'b0;
        $display("rd  addr=0 data=%h (coincident capture)", Dout);
        n_cmp++; if (Dout !== 32'hCAFE0000) begin n_err++; $display("FAIL same_rd_old: got %h expected %h", Dout, 32'hCAFE0000); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL same_rd_ready: got %b expected 1", irq); end
        key = 1'b0; tick(12);
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL same_rd_status: got %h expected %h", v, 32'h1); end
        rd(2'b00, v);
        n_cmp++; if (v !== 32'h0BADF00D) begin n_err++; $display("FAIL same_rd_new: got %h expected %h", v, 32'h0BADF00D); end

        key = 1'b1; tick(CAP_LAT - 1);
        WeDEVI = 1'b1; DEV_Addr = 2'b11; Din = 32'h12340100;
        tick(1);
        WeDEVI = 1'b0;
        $display("wr  addr=3 data=%h (coincident capture)", Din);
        key = 1'b0; tick(12);
        rd(2'b11, v);
        n_cmp++; if (v !== 32'h101) begin n_err++; $display("FAIL same_wr_count: got %h expected %h", v, 32'h101); end
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL same_wr_status: got %h expected %h", v, 32'h1); end

        key = 1'b1; tick(CAP_LAT - 1);
        WeDEVI = 1'b1; DEV_Addr = 2'b01; Din = 32'h2;
        tick(1);
        WeDEVI = 1'b0;
        $display("wr  addr=1 data=%h (coincident capture)", Din);
        key = 1'b0; tick(12);
        rd(2'b01, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL same_ovr_wins: got %h expected %h", v, 32'h3); end
        wr(2'b01, 32'h2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        rd(2'b10, v);
        key = 1'b1; tick(5);
        rst = 1'b0; #1;
        n_cmp++; if (Dout !== 32'h0) begin n_err++; $display("FAIL mid_rst_dout: got %h expected %h", Dout, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_rst_irq: got %b expected 0", irq); end
        ReDEVI = 1'b1; DEV_Addr = 2'b10;
        tick(2);
        ReDEVI = 1'b0;
        n_cmp++; if (Dout !== 32'h0) begin n_err++; $display("FAIL mid_rst_read: got %h expected %h", Dout, 32'h0); end
        rst = 1'b1;
        tick(CAP_LAT - 1);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_early_cap: got %b expected 0", irq); end
        tick(1);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mid_cap: got %b expected 1", irq); end
        key = 1'b0; tick(12);
        rd(2'b11, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL mid_count: got %h expected %h", v, 32'h1); end
        rd(2'b00, v);
        n_cmp++; if (v !== 32'h0BADF00D) begin n_err++; $display("FAIL mid_data: got %h expected %h", v, 32'h0BADF00D); end
    endtask

    task automatic test_short_pulse();
        logic [31:0] v;
        logic [31:0] exp_st;
        logic [31:0] exp_data;
`ifdef INPUT32_DEBOUNCE_EN
        exp_st = 32'h0; exp_data = 32'h0BADF00D;
`else
        exp_st = 32'h1; exp_data = 32'h12345678;
`endif
        sw = 32'h12345678;
        tick(3);
        key = 1'b1; tick(1);
        key = 1'b0; tick(10);
        rd(2'b01, v);
        n_cmp++; if (v !== exp_st) begin n_err++; $display("FAIL pulse_status: got %h expected %h", v, exp_st); end
        rd(2'b00, v);
        n_cmp++; if (v !== exp_data) begin n_err++; $display("FAIL pulse_data: got %h expected %h", v, exp_data); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_write_ignored();
        test_bounce();
        test_overrun();
        test_wrap();
        test_same_cycle();
        test_reset_mid();
        test_short_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
